// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: serialises one LANES-wide register into LANES element accesses on the data-memory port.
// Latency: store done at cycle LANES+1, load done at cycle LANES+2 after start; all outputs registered.
// Backpressure: holds busy from the cycle after start through done; start while busy is ignored. Option macro: VMEM_STRIDE_EN.
module vector_mem_sequencer #(
   parameter int LANES  = 4,
   parameter int ELEM_W = 8,
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      is_store,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [LANES*ELEM_W-1:0]   vdata_in,
`ifdef VMEM_STRIDE_EN
   input  logic [ADDR_W-1:0]         stride,
`endif
   output logic                      busy,
   output logic                      done,
   output logic [LANES*ELEM_W-1:0]   vdata_out,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_re,
   output logic                      mem_we,
   output logic [ELEM_W-1:0]         mem_wdata,
   input  logic [ELEM_W-1:0]         mem_rdata
);

   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int VEC_W = LANES * ELEM_W;
   localparam int ASM_W = (LANES - 1) * ELEM_W;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               store_q;
   // Remaining store elements; the next lane to write always sits in the low element.
   logic [VEC_W-1:0]   wvec_q;
   // Load assembly: holds the first LANES-1 elements, lane 0 at the bottom.
   logic [ASM_W-1:0]   asm_q;
   logic [VEC_W-1:0]   asm_next;
   logic [ADDR_W-1:0]  step;
   logic               capture;

`ifdef VMEM_STRIDE_EN
   logic [ADDR_W-1:0]  stride_q;

   // Stride is latched with the request so the pipeline may change it mid-transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         stride_q <= '0;
      end else if (state == IDLE && start) begin
         stride_q <= stride;
      end
   end

   assign step = stride_q;
`else
   assign step = ADDR_W'(1);
`endif

   // Incoming element shifts in from the top, so after the last read lane k lands at bits [k*ELEM_W +: ELEM_W].
   assign asm_next = {mem_rdata, asm_q};

   // Read data returns one cycle after each strobe: lanes 0..LANES-2 arrive during XFER (counter >= 1), the last in DRAIN.
   assign capture = ~store_q && ((state == XFER && cnt != '0) || state == DRAIN);

   // Main sequencer: state, lane counter, registered memory-port strobes and completion outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         store_q   <= 1'b0;
         wvec_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         vdata_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Lane 0 is issued straight from the request so cycle 1 already carries it.
                  state     <= XFER;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  store_q   <= is_store;
                  mem_addr  <= base_addr;
                  mem_we    <= is_store;
                  mem_re    <= ~is_store;
                  mem_wdata <= vdata_in[ELEM_W-1:0];
                  wvec_q    <= vdata_in >> ELEM_W;
               end
            end
            XFER: begin
               if (cnt == LAST_LANE) begin
                  mem_we <= 1'b0;
                  mem_re <= 1'b0;
                  if (store_q) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  // Incremental addressing keeps the datapath multiplier-free; wrap is modulo 2^ADDR_W.
                  cnt       <= cnt + 1'b1;
                  mem_addr  <= mem_addr + step;
                  mem_wdata <= wvec_q[ELEM_W-1:0];
                  wvec_q    <= wvec_q >> ELEM_W;
               end
            end
            DRAIN: begin
               // The last lane is folded in on the way out so vdata_out is complete as done rises.
               state     <= DONE;
               done      <= 1'b1;
               vdata_out <= asm_next;
            end
            DONE: begin
               // A start seen here is deliberately dropped; the next request is taken from IDLE.
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Load assembly register, advanced once per returned element.
   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q <= '0;
      end else if (capture) begin
         asm_q <= asm_next[VEC_W-1:ELEM_W];
      end
   end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
`timescale 1ns/1ps
module tb_vector_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [31:0] base_addr;
   logic [31:0] stride;
   logic [31:0] vdata_in;
   logic        busy;
   logic        done;
   logic [31:0] vdata_out;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   always #5 clk = ~clk;

   vector_mem_sequencer #(.LANES(4), .ELEM_W(8), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_store  (is_store),
      .base_addr (base_addr),
      .vdata_in  (vdata_in),
`ifdef VMEM_STRIDE_EN
      .stride    (stride),
`endif
      .busy      (busy),
      .done      (done),
      .vdata_out (vdata_out),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] addr;
      logic [7:0]  data;
   } acc_t;

   acc_t        exp_wr[$];
   acc_t        obs_wr[$];
   acc_t        exp_rd[$];
   acc_t        obs_rd[$];
   int          done_cyc[$];
   logic [31:0] busy_mask;
   logic [31:0] vout_hist [0:31];
   logic [7:0]  mem [logic [31:0]];
   logic        pend_re;
   logic [31:0] pend_addr;
   logic [31:0] exp_vout;
   int          checks;
   int          errors;

   function automatic acc_t mk(input int c, input logic [31:0] a, input logic [7:0] d);
      acc_t r;
      r.cyc  = 32'(c);
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   // Drives one request (edge 0 = first posedge), then observes cycles 1..ncyc as memory + recorder.
   task automatic run_op(input logic st, input logic [31:0] base, input logic [31:0] vec,
                         input int ncyc, input int s_a, input int s_b, input int rst_at);
      obs_wr.delete();
      obs_rd.delete();
      done_cyc.delete();
      busy_mask = '0;
      is_store  = st;
      base_addr = base;
      vdata_in  = vec;
      start     = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         mem_rdata = pend_re ? (mem.exists(pend_addr) ? mem[pend_addr] : 8'h00) : 8'hEE;
         pend_re   = mem_re;
         pend_addr = mem_addr;
         if (mem_we) begin
            obs_wr.push_back(mk(c, mem_addr, mem_wdata));
            mem[mem_addr] = mem_wdata;
         end
         if (mem_re) obs_rd.push_back(mk(c, mem_addr, 8'h00));
         if (done) done_cyc.push_back(c);
         busy_mask[c] = busy;
         vout_hist[c] = vdata_out;
         start     = (c == s_a) || (c == s_b);
         rst       = (c == rst_at);
         is_store  = ~st;
         base_addr = ~base;
         vdata_in  = ~vec;
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; is_store = 1'b1; base_addr = 32'h55; vdata_in = '1;
      mem_rdata = 8'hEE; pend_re = 1'b0; pend_addr = '0; stride = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, mem_re, mem_we} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/done/re/we=%b expected 0000", {busy, done, mem_re, mem_we});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 40'h0) begin
         errors++;
         $display("FAIL reset_port: addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
      end
      checks++;
      if (vdata_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_vout: got %h expected 0", vdata_out);
      end
      rst = 1'b0; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, mem_we, mem_re} !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle: busy/we/re=%b expected 000", {busy, mem_we, mem_re});
      end
      exp_vout = 32'h0;
   endtask

   task automatic test_store();
      logic [31:0] vec = 32'h44332211;
      acc_t e, o;
      stride = 32'd1;
      for (int k = 0; k < 4; k++) exp_wr.push_back(mk(k + 1, 32'h100 + k * stride, vec[k*8 +: 8]));
      run_op(1'b1, 32'h100, vec, 8, 0, 0, 0);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
         errors++;
         $display("FAIL store_count: got %0d writes expected %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL store_write: got cyc %0d %h@%h expected cyc %0d %h@%h", o.cyc, o.data, o.addr, e.cyc, e.data, e.addr);
         end
      end
      exp_wr.delete();
      checks++;
      if (done_cyc.size() != 1 || (done_cyc.size() > 0 ? done_cyc[0] : -1) != 5) begin
         errors++;
         $display("FAIL store_done: got %0d pulses first at %0d expected 1 at 5", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      checks++;
      if (busy_mask !== 32'h0000003E) begin
         errors++;
         $display("FAIL store_busy: got mask %h expected 0000003e", busy_mask);
      end
      checks++;
      if (obs_rd.size() != 0 || vout_hist[8] !== exp_vout) begin
         errors++;
         $display("FAIL store_side: got %0d reads vout %h expected 0 reads vout %h", obs_rd.size(), vout_hist[8], exp_vout);
      end
   endtask

   task automatic test_load();
      acc_t e, o;
      stride = 32'd1;
      mem[32'h200] = 8'hAA; mem[32'h201] = 8'hBB; mem[32'h202] = 8'hCC; mem[32'h203] = 8'hDD;
      for (int k = 0; k < 4; k++) exp_rd.push_back(mk(k + 1, 32'h200 + k * stride, 8'h00));
      exp_vout = 32'hDDCCBBAA;
      run_op(1'b0, 32'h200, 32'h0, 8, 0, 0, 0);
      checks++;
      if (obs_rd.size() != exp_rd.size() || obs_wr.size() != 0) begin
         errors++;
         $display("FAIL load_count: got %0d reads %0d writes expected %0d reads 0 writes", obs_rd.size(), obs_wr.size(), exp_rd.size());
      end
      while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
         e = exp_rd.pop_front();
         o = obs_rd.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL load_read: got cyc %0d @%h expected cyc %0d @%h", o.cyc, o.addr, e.cyc, e.addr);
         end
      end
      exp_rd.delete();
      checks++;
      if (done_cyc.size() != 1 || (done_cyc.size() > 0 ? done_cyc[0] : -1) != 6) begin
         errors++;
         $display("FAIL load_done: got %0d pulses first at %0d expected 1 at 6", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      checks++;
      if (vout_hist[6] !== exp_vout || vout_hist[8] !== exp_vout) begin
         errors++;
         $display("FAIL load_vout: got %h (done) %h (after) expected %h", vout_hist[6], vout_hist[8], exp_vout);
      end
      checks++;
      if (busy_mask !== 32'h0000007E) begin
         errors++;
         $display("FAIL load_busy: got mask %h expected 0000007e", busy_mask);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] vec = 32'hA4A3A2A1;
      logic [31:0] base = 32'hFFFFFFFE;
      acc_t e, o;
      stride = 32'd1;
      for (int k = 0; k < 4; k++) exp_wr.push_back(mk(k + 1, base + k * stride, vec[k*8 +: 8]));
      run_op(1'b1, base, vec, 8, 0, 0, 0);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
         errors++;
         $display("FAIL wrap_count: got %0d writes expected %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap_write: got cyc %0d %h@%h expected cyc %0d %h@%h", o.cyc, o.data, o.addr, e.cyc, e.data, e.addr);
         end
      end
      exp_wr.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vec = 32'h5A6B7C8D;
      acc_t e, o;
      stride = 32'd1;
      for (int k = 0; k < 4; k++) exp_wr.push_back(mk(k + 1, 32'h300 + k * stride, vec[k*8 +: 8]));
      run_op(1'b1, 32'h300, vec, 10, 2, 5, 0);
      checks++;
      if (obs_wr.size() != exp_wr.size() || obs_rd.size() != 0) begin
         errors++;
         $display("FAIL guard_count: got %0d writes %0d reads expected %0d writes 0 reads", obs_wr.size(), obs_rd.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL guard_write: got cyc %0d %h@%h expected cyc %0d %h@%h", o.cyc, o.data, o.addr, e.cyc, e.data, e.addr);
         end
      end
      exp_wr.delete();
      checks++;
      if (done_cyc.size() != 1 || busy_mask !== 32'h0000003E) begin
         errors++;
         $display("FAIL guard_done: got %0d pulses busy mask %h expected 1 pulse mask 0000003e", done_cyc.size(), busy_mask);
      end
   endtask

   task automatic test_reset_mid();
      stride = 32'd1;
      run_op(1'b0, 32'h200, 32'h0, 5, 0, 0, 2);
      exp_vout = 32'h0;
      checks++;
      if (busy_mask !== 32'h00000006 || obs_rd.size() != 2) begin
         errors++;
         $display("FAIL rstmid_abort: got busy mask %h reads %0d expected 00000006 and 2", busy_mask, obs_rd.size());
      end
      checks++;
      if (vout_hist[3] !== exp_vout || done_cyc.size() != 0) begin
         errors++;
         $display("FAIL rstmid_vout: got vout %h done pulses %0d expected %h and 0", vout_hist[3], done_cyc.size(), exp_vout);
      end
      mem[32'h400] = 8'h01; mem[32'h401] = 8'h02; mem[32'h402] = 8'h03; mem[32'h403] = 8'h04;
      exp_vout = 32'h04030201;
      run_op(1'b0, 32'h400, 32'h0, 8, 0, 0, 0);
      checks++;
      if (done_cyc.size() != 1 || (done_cyc.size() > 0 ? done_cyc[0] : -1) != 6 || vout_hist[6] !== exp_vout) begin
         errors++;
         $display("FAIL rstmid_fresh: got %0d pulses vout %h expected 1 at 6 vout %h", done_cyc.size(), vout_hist[6], exp_vout);
      end
   endtask

`ifdef VMEM_STRIDE_EN
   task automatic test_stride();
      logic [31:0] vec = 32'h0D0C0B0A;
      acc_t e, o;
      stride = 32'd4;
      for (int k = 0; k < 4; k++) exp_wr.push_back(mk(k + 1, 32'h10 + k * stride, vec[k*8 +: 8]));
      run_op(1'b1, 32'h10, vec, 8, 0, 0, 0);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
         errors++;
         $display("FAIL stride_count: got %0d writes expected %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stride_write: got cyc %0d %h@%h expected cyc %0d %h@%h", o.cyc, o.data, o.addr, e.cyc, e.data, e.addr);
         end
      end
      exp_wr.delete();
      stride = 32'd0;
      exp_vout = {4{mem[32'h200]}};
      run_op(1'b0, 32'h200, 32'h0, 8, 0, 0, 0);
      checks++;
      if (vout_hist[6] !== exp_vout) begin
         errors++;
         $display("FAIL stride_zero: got vout %h expected %h", vout_hist[6], exp_vout);
      end
      stride = 32'd1;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_store();
      test_load();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
`ifdef VMEM_STRIDE_EN
      test_stride();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
